// File: rtl/mtr_pkg.sv
// Shared definitions for the BLDC commutator: coil select codes, FSM states, commutation table.
// Latency: none (types, constants and a pure combinational function).
// Backpressure: not applicable.
package mtr_pkg;

  localparam logic [1:0] SEL_COAST = 2'b00;
  localparam logic [1:0] SEL_FWD   = 2'b01;
  localparam logic [1:0] SEL_REV   = 2'b10;
  localparam logic [1:0] SEL_BRK   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BRAKE = 2'd2,
    STALL = 2'd3
  } mtr_state_t;

  // Per-coil select bundle, green in the top bits.
  typedef struct packed {
    logic [1:0] grn;
    logic [1:0] ylw;
    logic [1:0] blu;
  } coil_sel_t;

  // Forward commutation: hall {G,Y,B} -> coil selects. Invalid codes coast all coils.
  function automatic coil_sel_t commutate(input logic [2:0] hall);
    coil_sel_t s;
    s = '0;
    case (hall)
      3'b101:  s = '{grn: SEL_REV,   ylw: SEL_FWD,   blu: SEL_COAST};
      3'b100:  s = '{grn: SEL_REV,   ylw: SEL_COAST, blu: SEL_FWD};
      3'b110:  s = '{grn: SEL_COAST, ylw: SEL_REV,   blu: SEL_FWD};
      3'b010:  s = '{grn: SEL_FWD,   ylw: SEL_REV,   blu: SEL_COAST};
      3'b011:  s = '{grn: SEL_FWD,   ylw: SEL_COAST, blu: SEL_REV};
      3'b001:  s = '{grn: SEL_COAST, ylw: SEL_FWD,   blu: SEL_REV};
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/duty_slew.sv
// Slew-limited duty register: moves toward target by at most step per enabled cycle, or loads directly.
// Latency: 1 clk from en/ld to duty.
// Backpressure: none; en and ld are single-cycle strobes, ld wins over en.
module duty_slew (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        ld,
  input  logic [10:0] ld_val,
  input  logic [10:0] target,
  input  logic [10:0] step,
  output logic [10:0] duty
);

  logic [11:0] tgt12;
  logic [11:0] duty12;
  logic [11:0] step12;
  logic [11:0] diff_up;
  logic [11:0] diff_dn;
  logic [11:0] up;
  logic [10:0] dn;
  logic [10:0] duty_nxt;

  // Next slewed duty, worked at 12 bits so the step cannot wrap past either rail.
  always_comb begin
    tgt12    = {1'b0, target};
    duty12   = {1'b0, duty};
    step12   = {1'b0, step};
    diff_up  = tgt12 - duty12;
    diff_dn  = duty12 - tgt12;
    up       = duty12 + step12;
    dn       = (duty > step) ? (duty - step) : 11'd0;
    duty_nxt = duty;
    if (tgt12 >= duty12) begin
      if (diff_up <= step12)   duty_nxt = target;
      else if (up > 12'h7FF)   duty_nxt = 11'h7FF;
      else                     duty_nxt = up[10:0];
    end else begin
      if (diff_dn <= step12)   duty_nxt = target;
      else                     duty_nxt = dn;
    end
  end

  // Duty register: direct load for brake/stall, slew otherwise.
  always_ff @(posedge clk) begin
    if (rst)      duty <= 11'd0;
    else if (ld)  duty <= ld_val;
    else if (en)  duty <= duty_nxt;
  end

endmodule

// File: rtl/bldc_commutator.sv
// Hall-synchronised commutation and duty sequencer with brake, stall and invalid-hall handling.
// Latency: 2 clk hall/brake synchroniser; sel/duty/stall update 1 clk after PWM_synch.
// Backpressure: none; all state advances only on the PWM_synch strobe.
module bldc_commutator
  import mtr_pkg::*;
#(
  parameter logic [10:0] DUTY_STEP     = 11'd16,
  parameter logic [10:0] BRAKE_DUTY    = 11'h600,
  parameter logic [15:0] STALL_PERIODS = 16'd2000,
  parameter logic [11:0] MIN_DRV       = 12'h020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hallGrn,
  input  logic        hallYlw,
  input  logic        hallBlu,
  input  logic        brake_n,
  input  logic [11:0] drv_mag,
  input  logic        PWM_synch,
  output logic [10:0] duty,
  output logic [1:0]  selGrn,
  output logic [1:0]  selYlw,
  output logic [1:0]  selBlu,
  output logic        stall,
  output logic        hall_err
);

  logic [2:0]  hall_s1, hall_s2, hall_q;
  logic        brk_s1, brk_s2;
  mtr_state_t  state, nxt_state;
  logic [15:0] stall_cnt, cnt_inc;
  logic        brake, low_dmd, hall_chg, hall_bad, stall_hit;
  coil_sel_t   sel_nxt, sel_q;
  logic        slew_en, slew_ld;
  logic [10:0] slew_ld_val, slew_tgt;

  // Two-flop synchronisers; brake_n idles high so reset does not look like a brake request.
  always_ff @(posedge clk) begin
    if (rst) begin
      hall_s1 <= 3'b000;
      hall_s2 <= 3'b000;
      brk_s1  <= 1'b1;
      brk_s2  <= 1'b1;
    end else begin
      hall_s1 <= {hallGrn, hallYlw, hallBlu};
      hall_s2 <= hall_s1;
      brk_s1  <= brake_n;
      brk_s2  <= brk_s1;
    end
  end

  // Next-state decision, evaluated against the hall sample taken at this PWM boundary.
  always_comb begin
    brake     = ~brk_s2;
    low_dmd   = (drv_mag <= MIN_DRV);
    hall_chg  = (hall_s2 != hall_q);
    hall_bad  = (hall_s2 == 3'b000) || (hall_s2 == 3'b111);
    cnt_inc   = (stall_cnt >= STALL_PERIODS) ? STALL_PERIODS : stall_cnt + 16'd1;
    // A hall edge in the threshold period clears the count, so it never stalls.
    stall_hit = !hall_chg && (cnt_inc >= STALL_PERIODS);
    nxt_state = state;
    case (state)
      IDLE: begin
        if (brake)         nxt_state = BRAKE;
        else if (!low_dmd) nxt_state = RUN;
      end
      RUN: begin
        if (brake)                           nxt_state = BRAKE;
        else if (low_dmd && duty == 11'd0)   nxt_state = IDLE;
        else if (stall_hit)                  nxt_state = STALL;
      end
      BRAKE: begin
        if (!brake)        nxt_state = IDLE;
      end
      STALL: begin
        if (brake)         nxt_state = BRAKE;
        else if (low_dmd)  nxt_state = IDLE;
      end
      default:             nxt_state = IDLE;
    endcase
  end

  // Coil selects and duty control follow the state being entered at this boundary.
  always_comb begin
    sel_nxt = '0;
    if (nxt_state == RUN)
      sel_nxt = commutate(hall_s2);
    else if (nxt_state == BRAKE)
      sel_nxt = '{grn: SEL_BRK, ylw: SEL_BRK, blu: SEL_BRK};
    slew_ld     = PWM_synch && (nxt_state == BRAKE || nxt_state == STALL || state == BRAKE);
    slew_ld_val = (nxt_state == BRAKE) ? BRAKE_DUTY : 11'd0;
    slew_en     = PWM_synch && (nxt_state == IDLE || nxt_state == RUN);
    slew_tgt    = (nxt_state == RUN) ? drv_mag[11:1] : 11'd0;
  end

  // Sequencer: state, hall latch, stall counter and registered outputs, advanced per PWM period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hall_q    <= 3'b000;
      stall_cnt <= 16'd0;
      sel_q     <= '0;
      stall     <= 1'b0;
      hall_err  <= 1'b0;
    end else if (PWM_synch) begin
      state  <= nxt_state;
      hall_q <= hall_s2;
      sel_q  <= sel_nxt;
      stall  <= (nxt_state == STALL);
      if (hall_bad)
        hall_err <= 1'b1;
      if (state == RUN && nxt_state == RUN)
        stall_cnt <= hall_chg ? 16'd0 : cnt_inc;
      else
        stall_cnt <= 16'd0;
    end
  end

  duty_slew u_duty_slew (
    .clk    (clk),
    .rst    (rst),
    .en     (slew_en),
    .ld     (slew_ld),
    .ld_val (slew_ld_val),
    .target (slew_tgt),
    .step   (DUTY_STEP),
    .duty   (duty)
  );

  assign selGrn = sel_q.grn;
  assign selYlw = sel_q.ylw;
  assign selBlu = sel_q.blu;

endmodule

// File: tb/tb_bldc_commutator.sv
// Self-checking bench for bldc_commutator: per-period scoreboard plus hall table and corner sequences.
// Latency: expectations are pushed before each PWM_synch and popped one clk later.
// Backpressure: not applicable.
module tb_bldc_commutator;

  logic        clk = 1'b0;
  logic        rst;
  logic        hallGrn, hallYlw, hallBlu;
  logic        brake_n;
  logic [11:0] drv_mag;
  logic        PWM_synch;
  logic [10:0] duty;
  logic [1:0]  selGrn, selYlw, selBlu;
  logic        stall, hall_err;

  always #5 clk = ~clk;

  bldc_commutator dut (
    .clk       (clk),
    .rst       (rst),
    .hallGrn   (hallGrn),
    .hallYlw   (hallYlw),
    .hallBlu   (hallBlu),
    .brake_n   (brake_n),
    .drv_mag   (drv_mag),
    .PWM_synch (PWM_synch),
    .duty      (duty),
    .selGrn    (selGrn),
    .selYlw    (selYlw),
    .selBlu    (selBlu),
    .stall     (stall),
    .hall_err  (hall_err)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [10:0] duty;
    logic [5:0]  sel;
    logic        stall;
    logic        err;
  } obs_t;

  obs_t exp_q[$];

  typedef enum int {M_IDLE, M_RUN, M_BRAKE, M_STALL} mst_t;
  mst_t       m_st;
  int         m_duty;
  int         m_cnt;
  logic [2:0] m_hq;
  logic       m_err;
  logic [5:0] m_sel;
  logic       m_stall;
  logic [5:0] comm_tbl [8];

  typedef struct {
    logic [2:0] hall;
    logic [5:0] sel;
    logic       err;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic obs_t observe();
    return {duty, selGrn, selYlw, selBlu, stall, hall_err};
  endfunction

  task automatic set_halls(input logic [2:0] h);
    {hallGrn, hallYlw, hallBlu} = h;
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_duty = 0; m_cnt = 0; m_hq = 3'b000;
    m_err = 1'b0; m_sel = 6'b0; m_stall = 1'b0;
  endtask

  // Reference behaviour for one PWM boundary using the (already settled) inputs.
  task automatic model_step();
    logic [2:0] hn;
    logic chg, brk, low;
    mst_t nx;
    int tgt, c;
    hn  = {hallGrn, hallYlw, hallBlu};
    chg = (hn != m_hq);
    m_hq = hn;
    if (hn == 3'b000 || hn == 3'b111) m_err = 1'b1;
    brk = !brake_n;
    low = (drv_mag <= 12'h020);
    nx = m_st;
    c = 0;
    case (m_st)
      M_IDLE:  if (brk) nx = M_BRAKE; else if (!low) nx = M_RUN;
      M_RUN: begin
        c = chg ? 0 : ((m_cnt + 1 > 2000) ? 2000 : m_cnt + 1);
        if (brk) nx = M_BRAKE;
        else if (low && m_duty == 0) nx = M_IDLE;
        else if (c == 2000) nx = M_STALL;
      end
      M_BRAKE: if (!brk) nx = M_IDLE;
      M_STALL: if (brk) nx = M_BRAKE; else if (low) nx = M_IDLE;
      default: nx = M_IDLE;
    endcase
    m_cnt = (m_st == M_RUN && nx == M_RUN) ? c : 0;
    if (nx == M_BRAKE) m_duty = 'h600;
    else if (nx == M_STALL || m_st == M_BRAKE) m_duty = 0;
    else begin
      tgt = (nx == M_RUN) ? int'(drv_mag) / 2 : 0;
      if (tgt - m_duty > 16)      m_duty = m_duty + 16;
      else if (m_duty - tgt > 16) m_duty = m_duty - 16;
      else                        m_duty = tgt;
    end
    m_sel   = (nx == M_RUN) ? comm_tbl[hn] : ((nx == M_BRAKE) ? 6'b111111 : 6'b000000);
    m_stall = (nx == M_STALL);
    m_st    = nx;
    exp_q.push_back({m_duty[10:0], m_sel, m_stall, m_err});
  endtask

  // One PWM period of 'gap' clocks ending with the PWM_synch pulse; called and returns at a negedge.
  task automatic period(input int gap);
    obs_t e, a;
    repeat (gap - 1) @(negedge clk);
    model_step();
    PWM_synch = 1'b1;
    @(negedge clk);
    PWM_synch = 1'b0;
    a = observe();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expectation queued");
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard: got duty=%0h sel=%b stall=%b err=%b want duty=%0h sel=%b stall=%b err=%b",
                 a.duty, a.sel, a.stall, a.err, e.duty, e.sel, e.stall, e.err);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [5:0] prev_sel;

    comm_tbl[0] = 6'b000000; comm_tbl[1] = 6'b000110;
    comm_tbl[2] = 6'b011000; comm_tbl[3] = 6'b010010;
    comm_tbl[4] = 6'b100001; comm_tbl[5] = 6'b100100;
    comm_tbl[6] = 6'b001001; comm_tbl[7] = 6'b000000;

    tbl[0] = '{3'b100, 6'b100001, 1'b0};
    tbl[1] = '{3'b110, 6'b001001, 1'b0};
    tbl[2] = '{3'b010, 6'b011000, 1'b0};
    tbl[3] = '{3'b011, 6'b010010, 1'b0};
    tbl[4] = '{3'b001, 6'b000110, 1'b0};
    tbl[5] = '{3'b101, 6'b100100, 1'b0};
    tbl[6] = '{3'b111, 6'b000000, 1'b1};
    tbl[7] = '{3'b101, 6'b100100, 1'b1};

    rst = 1'b1; PWM_synch = 1'b0; brake_n = 1'b1; drv_mag = 12'h800;
    set_halls(3'b101);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_duty", duty, 0);
    chk("reset_sel", {selGrn, selYlw, selBlu}, 0);
    chk("reset_stall", stall, 0);
    chk("reset_hall_err", hall_err, 0);

    // Ramp from IDLE into RUN.
    for (int i = 0; i < 64; i++) period(8);
    chk("ramp_duty_64", duty, 11'h400);
    chk("ramp_sel", {selGrn, selYlw, selBlu}, 6'b100100);

    // Hall table, including an invalid code and sticky error afterwards.
    for (int i = 0; i < 8; i++) begin
      prev_sel = {selGrn, selYlw, selBlu};
      set_halls(tbl[i].hall);
      repeat (3) @(negedge clk);
      chk("midperiod_sel", {selGrn, selYlw, selBlu}, prev_sel);
      period(5);
      chk("table_sel", {selGrn, selYlw, selBlu}, tbl[i].sel);
      chk("table_hall_err", hall_err, tbl[i].err);
    end
    chk("duty_before_brake", duty, 11'h400);

    // Brake and release.
    brake_n = 1'b0;
    period(8);
    chk("brake_duty", duty, 11'h600);
    chk("brake_sel", {selGrn, selYlw, selBlu}, 6'b111111);
    period(8);
    chk("brake_hold_duty", duty, 11'h600);
    brake_n = 1'b1;
    period(8);
    chk("release_duty", duty, 0);
    chk("release_sel", {selGrn, selYlw, selBlu}, 0);

    // Frozen halls -> stall exactly at the threshold period.
    period(8);
    chk("rerun_sel", {selGrn, selYlw, selBlu}, 6'b100100);
    for (int i = 0; i < 1999; i++) period(8);
    chk("stall_before_threshold", stall, 0);
    period(8);
    chk("stall_flag", stall, 1);
    chk("stall_sel", {selGrn, selYlw, selBlu}, 0);
    chk("stall_duty", duty, 0);
    for (int i = 0; i < 3; i++) period(8);
    chk("stall_hold", stall, 1);
    drv_mag = 12'h000;
    period(8);
    chk("stall_exit", stall, 0);

    // Mid-ramp reset clears everything including the sticky hall error.
    drv_mag = 12'h800;
    for (int i = 0; i < 32; i++) period(8);
    chk("midramp_duty", duty, 11'h200);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_duty", duty, 0);
    chk("rst_sel", {selGrn, selYlw, selBlu}, 0);
    chk("rst_stall", stall, 0);
    chk("rst_hall_err", hall_err, 0);

    // MIN_DRV boundary and RUN -> IDLE only once duty has reached zero.
    drv_mag = 12'h020;
    period(8);
    chk("min_drv_idle_sel", {selGrn, selYlw, selBlu}, 0);
    drv_mag = 12'h021;
    period(8);
    chk("above_min_run_sel", {selGrn, selYlw, selBlu}, 6'b100100);
    chk("above_min_duty", duty, 11'h010);
    drv_mag = 12'h020;
    period(8);
    chk("low_dmd_duty_nonzero_stays_run", {selGrn, selYlw, selBlu}, 6'b100100);
    drv_mag = 12'h000;
    period(8);
    chk("ramp_to_zero_duty", duty, 0);
    chk("ramp_to_zero_still_run", {selGrn, selYlw, selBlu}, 6'b100100);
    period(8);
    chk("back_to_idle_sel", {selGrn, selYlw, selBlu}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
